// File: rtl/bmu_cnt_pipe.sv
// Two-stage pipelined Zbb count unit (cpop/ctz/clz and W forms) with valid/ready and flush.
// Define BMU_CNTW_EN to build the 32-bit W-form operand conditioning when XLEN=64.
module bmu_cnt_pipe #(
    parameter int XLEN = 64
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] in_a,
    input  logic [1:0]      in_op,
    input  logic            in_word,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_res
);

    localparam int CW = $clog2(XLEN) + 1;
    localparam int NG = (XLEN + 2) / 3;

    localparam logic [1:0] OP_CPOP = 2'b00;
    localparam logic [1:0] OP_CTZ  = 2'b01;
    localparam logic [1:0] OP_CLZ  = 2'b10;

    logic            s1_valid_q, s1_valid_d;
    logic [XLEN-1:0] s1_y_q,     s1_y_d;
    logic            s2_valid_q, s2_valid_d;
    logic [CW-1:0]   s2_cnt_q,   s2_cnt_d;

    logic s1_ready;
    logic s2_ready;

    // The stall path from out_ready back to in_ready is deliberately combinational.
    assign s2_ready = !s2_valid_q | out_ready;
    assign s1_ready = !s1_valid_q | s2_ready;
    assign in_ready = s1_ready & !flush & resetn;

    // ------------------------------------------------------------------
    // Stage 1: reduce every operation to a population count of y.
    // ------------------------------------------------------------------
    logic [XLEN-1:0] rev_full;
    logic [XLEN-1:0] x_n;
    logic [XLEN-1:0] rev_n;
    logic [XLEN-1:0] mask_n;
    logic [XLEN-1:0] ctz_src;
    logic [XLEN-1:0] ctz_y;
    logic [XLEN-1:0] y;

    always_comb begin
        for (int i = 0; i < XLEN; i++) begin
            rev_full[i] = in_a[XLEN-1-i];
        end
    end

`ifdef BMU_CNTW_EN
    logic            w_mode;
    logic [XLEN-1:0] x_w;
    logic [XLEN-1:0] rev_w;

    if (XLEN == 64) begin : g_w_sel
        assign w_mode = in_word;
    end else begin : g_w_off
        logic unused_word;
        assign unused_word = in_word;
        assign w_mode      = 1'b0;
    end

    always_comb begin
        x_w   = XLEN'(in_a[31:0]);
        rev_w = '0;
        for (int i = 0; i < 32; i++) begin
            rev_w[i] = in_a[31-i];
        end
    end

    assign x_n    = w_mode ? x_w   : in_a;
    assign rev_n  = w_mode ? rev_w : rev_full;
    assign mask_n = w_mode ? XLEN'(32'hFFFF_FFFF) : {XLEN{1'b1}};
`else
    logic unused_word;
    assign unused_word = in_word;

    assign x_n    = in_a;
    assign rev_n  = rev_full;
    assign mask_n = {XLEN{1'b1}};
`endif

    // The mask keeps a zero W operand from borrowing into the upper half.
    assign ctz_src = (in_op == OP_CLZ) ? rev_n : x_n;
    assign ctz_y   = ~ctz_src & (ctz_src - XLEN'(1)) & mask_n;

    always_comb begin
        // NOTE: every combinational output gets a default first so no latch is inferred.
        y = '0;
        case (in_op)
            OP_CPOP: y = x_n;
            OP_CTZ,
            OP_CLZ:  y = ctz_y;
            default: y = '0;
        endcase
    end

    // ------------------------------------------------------------------
    // Stage 2: one 3:2 carry-save layer, then sum the sum and carry columns.
    // ------------------------------------------------------------------
    logic [3*NG-1:0] csa_in;
    logic [NG-1:0]   csa_s;
    logic [NG-1:0]   csa_c;
    logic [CW-1:0]   sum_s;
    logic [CW-1:0]   sum_c;
    logic [CW-1:0]   pop_cnt;

    always_comb begin
        csa_in = (3*NG)'(s1_y_q);
        sum_s  = '0;
        sum_c  = '0;
        for (int g = 0; g < NG; g++) begin
            csa_s[g] = csa_in[3*g] ^ csa_in[3*g+1] ^ csa_in[3*g+2];
            csa_c[g] = (csa_in[3*g]   & csa_in[3*g+1]) |
                       (csa_in[3*g]   & csa_in[3*g+2]) |
                       (csa_in[3*g+1] & csa_in[3*g+2]);
        end
        for (int g = 0; g < NG; g++) begin
            sum_s = sum_s + CW'(csa_s[g]);
            sum_c = sum_c + CW'(csa_c[g]);
        end
        pop_cnt = sum_s + (sum_c << 1);
    end

    // ------------------------------------------------------------------
    // Pipeline control
    // ------------------------------------------------------------------
    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_y_d     = s1_y_q;
        s2_valid_d = s2_valid_q;
        s2_cnt_d   = s2_cnt_q;
        if (flush) begin
            s1_valid_d = 1'b0;
            s2_valid_d = 1'b0;
        end else begin
            if (s2_ready) begin
                s2_valid_d = s1_valid_q;
                if (s1_valid_q) begin
                    s2_cnt_d = pop_cnt;
                end
            end
            if (s1_ready) begin
                s1_valid_d = in_valid;
                if (in_valid) begin
                    s1_y_d = y;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: data registers are reset too, because out_res must read zero after reset.
        if (!resetn) begin
            s1_valid_q <= 1'b0;
            s1_y_q     <= '0;
            s2_valid_q <= 1'b0;
            s2_cnt_q   <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            s1_valid_q <= s1_valid_d;
            s1_y_q     <= s1_y_d;
            s2_valid_q <= s2_valid_d;
            s2_cnt_q   <= s2_cnt_d;
        end
    end

    assign out_valid = s2_valid_q;
    assign out_res   = XLEN'(s2_cnt_q);

endmodule

// File: tb/tb_bmu_cnt_pipe.sv
// Self-checking bench for bmu_cnt_pipe: directed spec cases plus randomized traffic
// checked against a bit-counting reference model and an in-order result queue.
module tb_bmu_cnt_pipe;

    localparam int XLEN = 64;
`ifdef BMU_CNTW_EN
    localparam bit W_EN = 1'b1;
`else
    localparam bit W_EN = 1'b0;
`endif

    logic            clk;
    logic            resetn;
    logic            flush;
    logic            in_valid;
    logic            in_ready;
    logic [XLEN-1:0] in_a;
    logic [1:0]      in_op;
    logic            in_word;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_res;

    int n_cmp = 0;
    int n_bad = 0;

    logic [63:0] exp_q[$];

    bmu_cnt_pipe #(.XLEN(XLEN)) dut (
        .clk       (clk),
        .resetn    (resetn),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_op     (in_op),
        .in_word   (in_word),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_res   (out_res)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference: count bits directly over the effective width n.
    function automatic logic [63:0] ref_count(input logic [63:0] a, input logic [1:0] op,
                                              input logic word);
        int n;
        int cnt;
        int i;
        n   = (W_EN && word) ? 32 : 64;
        cnt = 0;
        case (op)
            2'b00: for (int k = 0; k < n; k++) if (a[k]) cnt++;
            2'b01: begin
                i = 0;
                while (i < n && !a[i]) i++;
                cnt = i;
            end
            2'b10: begin
                i = n - 1;
                while (i >= 0 && !a[i]) begin
                    cnt++;
                    i--;
                end
            end
            default: cnt = 0;
        endcase
        return 64'(cnt);
    endfunction

    task automatic idle_inputs();
        in_valid  = 1'b0;
        in_a      = '0;
        in_op     = 2'b00;
        in_word   = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b1;
    endtask

    // Issue one op into an empty pipe and return the first result it produces.
    task automatic do_op(input logic [63:0] a, input logic [1:0] op, input logic w,
                         output logic [63:0] res, output bit ok);
        bit acc;
        acc = 1'b0;
        ok  = 1'b0;
        res = '0;
        for (int k = 0; k < 20 && !acc; k++) begin
            @(negedge clk);
            in_valid  = 1'b1;
            in_a      = a;
            in_op     = op;
            in_word   = w;
            out_ready = 1'b1;
            #1;
            acc = in_ready;
        end
        @(negedge clk);
        in_valid = 1'b0;
        if (!acc) return;
        for (int k = 0; k < 20 && !ok; k++) begin
            if (out_valid) begin
                res = out_res;
                ok  = 1'b1;
            end else begin
                @(negedge clk);
            end
        end
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        idle_inputs();
        repeat (2) @(negedge clk);
        #1;
        n_cmp++;
        if (out_valid !== 1'b0 || out_res !== 64'd0) begin
            n_bad++;
            $display("FAIL reset_state: got valid=%b res=%h want valid=0 res=0", out_valid, out_res);
        end
        n_cmp++;
        if (in_ready !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_in_ready: got %b want 0", in_ready);
        end
        resetn = 1'b1;
        #1;
        n_cmp++;
        if (in_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL post_reset_in_ready: got %b want 1", in_ready);
        end
    endtask

    task automatic test_cpop_latency();
        @(negedge clk);
        in_valid  = 1'b1;
        in_a      = 64'hFFFF_0000_0000_00F0;
        in_op     = 2'b00;
        in_word   = 1'b0;
        out_ready = 1'b1;
        #1;
        n_cmp++;
        if (in_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL lat_accept: got in_ready=%b want 1", in_ready);
        end
        @(negedge clk);
        in_valid = 1'b0;
        n_cmp++;
        if (out_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL lat_early: got out_valid=%b want 0 one cycle after accept", out_valid);
        end
        @(negedge clk);
        n_cmp++;
        if (out_valid !== 1'b1 || out_res !== 64'd20) begin
            n_bad++;
            $display("FAIL lat_result: got valid=%b res=%0d want valid=1 res=20", out_valid, out_res);
        end
        @(negedge clk);
        n_cmp++;
        if (out_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL lat_nodup: got out_valid=%b want 0", out_valid);
        end
    endtask

    task automatic test_directed();
        logic [63:0] ta[10];
        logic [1:0]  top[10];
        logic        tw[10];
        logic [63:0] te[10];
        string       tn[10];
        logic [63:0] res;
        bit          ok;
        ta[0] = 64'h0;                   top[0] = 2'b01; tw[0] = 1'b0; te[0] = 64;             tn[0] = "ctz_zero";
        ta[1] = 64'hFFFF_FFFF_0000_0000; top[1] = 2'b01; tw[1] = 1'b1; te[1] = 32;             tn[1] = "ctzw_hi";
        ta[2] = 64'h1;                   top[2] = 2'b10; tw[2] = 1'b0; te[2] = 63;             tn[2] = "clz_one";
        ta[3] = 64'h1;                   top[3] = 2'b10; tw[3] = 1'b1; te[3] = W_EN ? 31 : 63; tn[3] = "clzw_one";
        ta[4] = 64'h8000_0000_0000_0000; top[4] = 2'b10; tw[4] = 1'b0; te[4] = 0;              tn[4] = "clz_msb";
        ta[5] = 64'h0;                   top[5] = 2'b01; tw[5] = 1'b1; te[5] = W_EN ? 32 : 64; tn[5] = "ctzw_zero";
        ta[6] = 64'hFFFF_FFFF_0000_0001; top[6] = 2'b00; tw[6] = 1'b1; te[6] = W_EN ? 1 : 33;  tn[6] = "cpopw";
        ta[7] = 64'hFFFF_FFFF_FFFF_FFFF; top[7] = 2'b11; tw[7] = 1'b0; te[7] = 0;              tn[7] = "reserved";
        ta[8] = 64'h0;                   top[8] = 2'b10; tw[8] = 1'b0; te[8] = 64;             tn[8] = "clz_zero";
        ta[9] = 64'hFFFF_FFFF_FFFF_FFFF; top[9] = 2'b00; tw[9] = 1'b0; te[9] = 64;             tn[9] = "cpop_ones";
        for (int i = 0; i < 10; i++) begin
            do_op(ta[i], top[i], tw[i], res, ok);
            n_cmp++;
            if (!ok || res !== te[i]) begin
                n_bad++;
                $display("FAIL %s: got %0d (done=%0d) want %0d", tn[i], res, ok, te[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [63:0] vals[4];
        logic [63:0] got[$];
        logic [63:0] held;
        int          sent;
        vals[0] = 64'd1; vals[1] = 64'd3; vals[2] = 64'd7; vals[3] = 64'd15;
        sent = 0;
        held = '0;
        for (int c = 0; c < 40 && got.size() < 4; c++) begin
            @(negedge clk);
            out_ready = (c >= 3);
            in_op     = 2'b00;
            in_word   = 1'b0;
            if (sent < 4) begin
                in_valid = 1'b1;
                in_a     = vals[sent];
            end else begin
                in_valid = 1'b0;
            end
            #1;
            if (c == 2) begin
                n_cmp++;
                if (in_ready !== 1'b0 || sent != 2) begin
                    n_bad++;
                    $display("FAIL b2b_backpressure: got in_ready=%b accepts=%0d want 0 after 2", in_ready, sent);
                end
                n_cmp++;
                if (out_valid !== 1'b1) begin
                    n_bad++;
                    $display("FAIL b2b_stall_valid: got %b want 1", out_valid);
                end
                held = out_res;
            end
            if (c == 3) begin
                n_cmp++;
                if (out_res !== held || out_valid !== 1'b1) begin
                    n_bad++;
                    $display("FAIL b2b_stable: got %0d want %0d", out_res, held);
                end
            end
            if (out_valid && out_ready) got.push_back(out_res);
            if (in_valid && in_ready) sent++;
        end
        @(negedge clk);
        idle_inputs();
        n_cmp++;
        if (got.size() != 4) begin
            n_bad++;
            $display("FAIL b2b_count: got %0d results want 4", got.size());
        end
        for (int i = 0; i < got.size() && i < 4; i++) begin
            n_cmp++;
            if (got[i] !== 64'(i + 1)) begin
                n_bad++;
                $display("FAIL b2b_order[%0d]: got %0d want %0d", i, got[i], i + 1);
            end
        end
    endtask

    task automatic test_flush();
        bit seen;
        int acc;
        acc = 0;
        out_ready = 1'b0;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_a     = 64'(c + 1);
            in_op    = 2'b00;
            #1;
            if (in_ready) acc++;
        end
        @(negedge clk);
        in_valid = 1'b1;
        in_a     = 64'hF;
        flush    = 1'b1;
        #1;
        n_cmp++;
        if (in_ready !== 1'b0 || acc != 2) begin
            n_bad++;
            $display("FAIL flush_in_ready: got in_ready=%b accepts=%0d want 0 after 2", in_ready, acc);
        end
        @(negedge clk);
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        n_cmp++;
        if (out_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL flush_clear: got out_valid=%b want 0", out_valid);
        end
        seen = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (out_valid !== 1'b0) seen = 1'b1;
        end
        n_cmp++;
        if (seen) begin
            n_bad++;
            $display("FAIL flush_leak: got a flushed result want none");
        end
    endtask

    task automatic test_reset_mid();
        logic [63:0] res;
        bit          ok;
        @(negedge clk);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_a      = 64'hFF;
        in_op     = 2'b00;
        in_word   = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (out_valid !== 1'b1 || out_res !== 64'd8) begin
            n_bad++;
            $display("FAIL rst_mid_stalled: got valid=%b res=%0d want 1/8", out_valid, out_res);
        end
        resetn = 1'b0;
        #1;
        n_cmp++;
        if (in_ready !== 1'b0) begin
            n_bad++;
            $display("FAIL rst_mid_in_ready: got %b want 0", in_ready);
        end
        @(negedge clk);
        resetn = 1'b1;
        n_cmp++;
        if (out_valid !== 1'b0 || out_res !== 64'd0) begin
            n_bad++;
            $display("FAIL rst_mid_clear: got valid=%b res=%0d want 0/0", out_valid, out_res);
        end
        do_op(64'h0000_F0F0_0000_0000, 2'b00, 1'b0, res, ok);
        n_cmp++;
        if (!ok || res !== 64'd8) begin
            n_bad++;
            $display("FAIL rst_mid_fresh: got %0d (done=%0d) want 8", res, ok);
        end
    endtask

    task automatic test_random();
        logic [63:0] held_val;
        logic [63:0] exp;
        bit          held;
        bit          exp_rdy;
        int          sel;
        held     = 1'b0;
        held_val = '0;
        exp_q.delete();
        for (int cyc = 0; cyc < 600; cyc++) begin
            @(negedge clk);
            sel = $urandom_range(0, 7);
            case (sel)
                0:       in_a = 64'h0;
                1:       in_a = 64'h1 << $urandom_range(0, 63);
                2:       in_a = 64'hFFFF_FFFF_FFFF_FFFF;
                default: in_a = {$urandom, $urandom};
            endcase
            in_op     = 2'($urandom_range(0, 3));
            in_word   = 1'($urandom_range(0, 1));
            in_valid  = ($urandom_range(0, 9) < 7);
            out_ready = ($urandom_range(0, 9) < 6);
            #1;
            exp_rdy = (exp_q.size() < 2) || out_ready;
            n_cmp++;
            if (in_ready !== exp_rdy) begin
                n_bad++;
                $display("FAIL rnd_in_ready@%0d: got %b want %b (occ=%0d)", cyc, in_ready, exp_rdy, exp_q.size());
            end
            if (held && out_valid) begin
                n_cmp++;
                if (out_res !== held_val) begin
                    n_bad++;
                    $display("FAIL rnd_stable@%0d: got %0d want %0d", cyc, out_res, held_val);
                end
            end
            held     = out_valid && !out_ready;
            held_val = out_res;
            if (out_valid && out_ready) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_bad++;
                    $display("FAIL rnd_spurious@%0d: got %0d want no result", cyc, out_res);
                end else begin
                    exp = exp_q.pop_front();
                    if (out_res !== exp) begin
                        n_bad++;
                        $display("FAIL rnd_result@%0d: got %0d want %0d", cyc, out_res, exp);
                    end
                end
            end
            if (in_valid && in_ready) exp_q.push_back(ref_count(in_a, in_op, in_word));
        end
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int k = 0; k < 10 && exp_q.size() > 0; k++) begin
            #1;
            if (out_valid) begin
                exp = exp_q.pop_front();
                n_cmp++;
                if (out_res !== exp) begin
                    n_bad++;
                    $display("FAIL rnd_drain: got %0d want %0d", out_res, exp);
                end
            end
            @(negedge clk);
        end
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL rnd_lost: got %0d results outstanding want 0", exp_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_cpop_latency();
        test_directed();
        test_back_to_back();
        test_flush();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
